// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode/operand-fetch stage with register file and registered valid/ready output
// Optional OPFETCH_WB_BYPASS_EN: same-cycle write-back value is forwarded to the operands being read.
module operand_fetch_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_in1,
  output logic [XLEN-1:0] out_in2,
  output logic [XLEN-1:0] out_aux,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_illegal
);

  localparam int         IW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] rf [NREGS];

  logic [4:0] rs1, rs2, rd;
  logic [6:0] opcode;
  logic       accept;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  // Out-of-range indices and x0 read as zero.
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && {1'b0, idx} < NREGS_W) v = rf[idx[IW-1:0]];
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_en && idx != 5'd0 && idx == wb_rd && {1'b0, idx} < NREGS_W) v = wb_data;
`endif
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf <= '{default: '0};
    end else if (wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < NREGS_W) begin
      rf[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] r1, r2;
  logic [XLEN-1:0] d_in1, d_in2, d_aux;
  logic            d_we, d_illegal;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    r1        = read_reg(rs1);
    r2        = read_reg(rs2);
    d_in1     = '0;
    d_in2     = '0;
    d_aux     = '0;
    d_we      = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        d_in1 = r1;
        d_in2 = r2;
        d_we  = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        d_in1 = r1;
        d_in2 = sext(imm_i);
        d_we  = 1'b1;
      end
      OP_STORE: begin
        d_in1 = r1;
        d_in2 = sext(imm_s);
        d_aux = r2;
      end
      OP_BRANCH: begin
        d_in1 = r1;
        d_in2 = r2;
        d_aux = sext(imm_b);
      end
      OP_JAL: begin
        d_in1 = pc;
        d_in2 = sext(imm_j);
        d_we  = 1'b1;
      end
      OP_LUI: begin
        d_in2 = sext(imm_u);
        d_we  = 1'b1;
      end
      OP_AUIPC: begin
        d_in1 = pc;
        d_in2 = sext(imm_u);
        d_we  = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (rd == 5'd0) d_we = 1'b0;
  end

  // Data outputs only load on accept, so they hold through stalls and after drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_in1     <= '0;
      out_in2     <= '0;
      out_aux     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_opcode  <= '0;
      out_func3   <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_in1     <= d_in1;
      out_in2     <= d_in2;
      out_aux     <= d_aux;
      out_rd      <= rd;
      out_rd_we   <= d_we;
      out_opcode  <= opcode;
      out_func3   <= instr[14:12];
      out_illegal <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - scoreboard bench for operand_fetch_stage (64/32 and 32/16 builds)
module tb_operand_fetch_stage;

  typedef struct packed {
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] aux;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, out_ready, wb_en;
  logic [31:0] instr;
  logic [63:0] pc, wb_data;
  logic [4:0]  wb_rd;

  logic        in_ready, out_valid, out_rd_we, out_illegal;
  logic [63:0] out_in1, out_in2, out_aux;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;

  logic        s_in_ready, s_out_valid, s_out_rd_we, s_out_illegal;
  logic [31:0] s_out_in1, s_out_in2, s_out_aux;
  logic [4:0]  s_out_rd;
  logic [6:0]  s_out_opcode;
  logic [2:0]  s_out_func3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  operand_fetch_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_in1(out_in1), .out_in2(out_in2),
    .out_aux(out_aux), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_illegal(out_illegal)
  );

  operand_fetch_stage #(.XLEN(32), .NREGS(16)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .pc(pc[31:0]), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_in1(s_out_in1), .out_in2(s_out_in2),
    .out_aux(s_out_aux), .out_rd(s_out_rd), .out_rd_we(s_out_rd_we), .out_opcode(s_out_opcode),
    .out_func3(s_out_func3), .out_illegal(s_out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic we, input logic ill);
    exp_t e;
    e.in1 = a; e.in2 = b; e.aux = c; e.rd = i[11:7]; e.rd_we = we;
    e.opc = i[6:0]; e.f3 = i[14:12]; e.ill = ill;
    return e;
  endfunction

  // Bundles are compared at the negedge preceding the transfer edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bundle: got rd=%0d in1=%h with nothing expected", out_rd, out_in1);
      end else begin
        e = exp_q.pop_front();
        if (out_in1 !== e.in1) begin
          errors++; $display("FAIL bundle_in1 rd=%0d: got %h expected %h", e.rd, out_in1, e.in1);
        end
        checks++;
        if (out_in2 !== e.in2) begin
          errors++; $display("FAIL bundle_in2 rd=%0d: got %h expected %h", e.rd, out_in2, e.in2);
        end
        checks++;
        if (out_aux !== e.aux) begin
          errors++; $display("FAIL bundle_aux rd=%0d: got %h expected %h", e.rd, out_aux, e.aux);
        end
        checks++;
        if ({out_rd, out_rd_we, out_opcode, out_func3, out_illegal} !== {e.rd, e.rd_we, e.opc, e.f3, e.ill}) begin
          errors++;
          $display("FAIL bundle_ctl: got rd=%0d we=%b op=%h f3=%0d ill=%b expected rd=%0d we=%b op=%h f3=%0d ill=%b",
                   out_rd, out_rd_we, out_opcode, out_func3, out_illegal, e.rd, e.rd_we, e.opc, e.f3, e.ill);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [63:0] p, input exp_t e);
    int n;
    in_valid = 1'b1; instr = i; pc = p;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b for instr %h", in_ready, i);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout: %0d bundles outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_in1 !== 64'd0 || out_in2 !== 64'd0 || out_aux !== 64'd0 || out_rd_we !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b in1=%h in2=%h, expected all 0", out_valid, out_in1, out_in2);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    send(32'hFFB00093, 64'd0, mk(32'hFFB00093, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL addi_latency: out_valid=%b expected 1", out_valid);
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_out_in2 !== 32'hFFFF_FFFB || s_out_rd_we !== 1'b1 || s_out_rd !== 5'd1) begin
      errors++; $display("FAIL addi_xlen32: got valid=%b in2=%h we=%b rd=%0d expected 1 fffffffb 1 1",
                         s_out_valid, s_out_in2, s_out_rd_we, s_out_rd);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_in2 !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      errors++; $display("FAIL addi_drop: got valid=%b in2=%h expected 0 fffffffffffffffb", out_valid, out_in2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_branch();
    wb(5'd2, 64'h10);
    wb(5'd3, 64'h20);
    send(32'h00312423, 64'd0, mk(32'h00312423, 64'h10, 64'd8, 64'h20, 1'b0, 1'b0));
    send(32'hFE310EE3, 64'd0, mk(32'hFE310EE3, 64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_bypass();
    logic [63:0] v;
`ifdef OPFETCH_WB_BYPASS_EN
    v = 64'hAA;
`else
    v = 64'd0;
`endif
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hAA;
    send(32'h00528333, 64'd0, mk(32'h00528333, v, v, 64'd0, 1'b1, 1'b0));
    wb_en = 1'b0;
    send(32'h00528333, 64'd0, mk(32'h00528333, 64'hAA, 64'hAA, 64'd0, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_nregs_bound();
    wb(5'd20, 64'h55);
    send(32'h014A06B3, 64'd0, mk(32'h014A06B3, 64'h55, 64'h55, 64'd0, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (s_out_in1 !== 32'd0 || s_out_in2 !== 32'd0) begin
      errors++; $display("FAIL nregs16_x20: got in1=%h in2=%h expected 0 0", s_out_in1, s_out_in2);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(32'h00100393, 64'd0, mk(32'h00100393, 64'd0, 64'd1, 64'd0, 1'b1, 1'b0));
    in_valid = 1'b1; instr = 32'h00200413;
    wb(5'd7, 64'h77);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_in2 !== 64'd1 || out_rd !== 5'd7 || out_in1 !== 64'd0) begin
        errors++; $display("FAIL stall_hold[%0d]: got in_ready=%b valid=%b in2=%h rd=%0d expected 0 1 1 7",
                           k, in_ready, out_valid, out_in2, out_rd);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00200413, 64'd0, mk(32'h00200413, 64'd0, 64'd2, 64'd0, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd8) begin
      errors++; $display("FAIL stall_release: got valid=%b rd=%0d expected 1 8", out_valid, out_rd);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_jal_illegal_x0();
    send(32'h008000EF, 64'h1000, mk(32'h008000EF, 64'h1000, 64'd8, 64'd0, 1'b1, 1'b0));
    send(32'h0001047F, 64'd0, mk(32'h0001047F, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1));
    drain();
    wb(5'd0, 64'hDEAD);
    send(32'h000004B3, 64'd0, mk(32'h000004B3, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0));
    send(32'h00500013, 64'd0, mk(32'h00500013, 64'd0, 64'd5, 64'd0, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    send(32'h80000537, 64'd0, mk(32'h80000537, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b1, 1'b0));
    send(32'h00001597, 64'h2000, mk(32'h00001597, 64'h2000, 64'h1000, 64'd0, 1'b1, 1'b0));
    send(32'h00528333, 64'd0, mk(32'h00528333, 64'hAA, 64'hAA, 64'd0, 1'b1, 1'b0));
    send(32'hFFB00093, 64'd0, mk(32'hFFB00093, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0));
    checks++;
    if (cyc - c0 != 4) begin
      errors++; $display("FAIL back_to_back_rate: took %0d cycles expected 4", cyc - c0);
    end
    drain();
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    send(32'hFFB00093, 64'd0, mk(32'hFFB00093, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0));
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_in2 !== 64'd0 || s_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_midstall: got valid=%b in2=%h expected 0 0", out_valid, out_in2);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00310633, 64'd0, mk(32'h00310633, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0));
    send(32'h00528333, 64'd0, mk(32'h00528333, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0));
    drain();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    wb_rd = '0; wb_data = '0; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_store_branch();
    test_bypass();
    test_nregs_bound();
    test_stall();
    test_jal_illegal_x0();
    test_back_to_back();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
